// File: rtl/stream_mux_nto1_if.sv
// Channel bundle of stream_mux_nto1: N producer streams in, one registered stream out.
// In_Last exists only when STREAM_MUX_LOCK_EN is defined.
interface stream_mux_nto1_if #(
   parameter int unsigned NBits     = 32,
   parameter int unsigned NChannels = 3,
   parameter int unsigned SelBits   = 2
);
   logic [NChannels-1:0]       In_Valid;
   logic [NChannels*NBits-1:0] In_Data;
   logic [NChannels-1:0]       In_Ready;
`ifdef STREAM_MUX_LOCK_EN
   logic [NChannels-1:0]       In_Last;
`endif
   logic                       Out_Valid;
   logic [NBits-1:0]           Out_Data;
   logic [SelBits-1:0]         Out_Channel;
   logic                       Out_Ready;

   // master: producers plus consumer (environment side); slave: the mux itself
   modport master (
      output In_Valid, In_Data, Out_Ready,
`ifdef STREAM_MUX_LOCK_EN
      output In_Last,
`endif
      input  In_Ready, Out_Valid, Out_Data, Out_Channel
   );

   modport slave (
      input  In_Valid, In_Data, Out_Ready,
`ifdef STREAM_MUX_LOCK_EN
      input  In_Last,
`endif
      output In_Ready, Out_Valid, Out_Data, Out_Channel
   );
endinterface

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with a registered output, fixed-select or round-robin grant.
// Define STREAM_MUX_LOCK_EN to add In_Last and hold the round-robin grant for a whole packet.
module stream_mux_nto1 #(
   parameter int unsigned NBits     = 32,
   parameter int unsigned NChannels = 3,
   parameter int unsigned SelBits   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Mode,
   input  logic [SelBits-1:0] Selector,
   stream_mux_nto1_if.slave   bus
);
   localparam logic [SelBits-1:0] LastIdx = SelBits'(NChannels - 1);

   logic                 out_valid_q;
   logic [NBits-1:0]     out_data_q;
   logic [SelBits-1:0]   out_channel_q;
   logic [SelBits-1:0]   last_grant_q;

   logic                 load_en;
   logic                 grant_valid;
   logic [SelBits-1:0]   grant_idx;
   logic [NBits-1:0]     grant_data;
   logic [NChannels-1:0] ready;
   logic                 transfer;

`ifdef STREAM_MUX_LOCK_EN
   logic                 lock_q;
   logic [SelBits-1:0]   lock_ch_q;
   logic                 grant_last;
`endif

   assign load_en = !out_valid_q || bus.Out_Ready;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      if (!Mode) begin
         // Out-of-range selectors simply never grant
         if (32'(Selector) < NChannels) begin
            grant_valid = 1'b1;
            grant_idx   = Selector;
         end
      end else begin
`ifdef STREAM_MUX_LOCK_EN
         if (lock_q) begin
            grant_valid = 1'b1;
            grant_idx   = lock_ch_q;
         end
`endif
         // Channels above the last grant first, then wrap to the lower ones
         for (int i = 0; i < int'(NChannels); i++) begin
            if (!grant_valid && bus.In_Valid[i] && (SelBits'(i) > last_grant_q)) begin
               grant_valid = 1'b1;
               grant_idx   = SelBits'(i);
            end
         end
         for (int i = 0; i < int'(NChannels); i++) begin
            if (!grant_valid && bus.In_Valid[i] && (SelBits'(i) <= last_grant_q)) begin
               grant_valid = 1'b1;
               grant_idx   = SelBits'(i);
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < int'(NChannels); i++) begin
         if (grant_idx == SelBits'(i)) begin
            grant_data = bus.In_Data[i*NBits +: NBits];
         end
      end
   end

   always_comb begin
      ready = '0;
      for (int i = 0; i < int'(NChannels); i++) begin
         ready[i] = !reset && load_en && grant_valid && (grant_idx == SelBits'(i)) &&
                    bus.In_Valid[i];
      end
   end

   assign transfer     = |ready;
   assign bus.In_Ready = ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_channel_q <= '0;
         last_grant_q  <= LastIdx;
      end else if (load_en) begin
         if (transfer) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= grant_data;
            out_channel_q <= grant_idx;
            if (Mode) begin
               last_grant_q <= grant_idx;
            end
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   always_comb begin
      grant_last = 1'b0;
      for (int i = 0; i < int'(NChannels); i++) begin
         if (grant_idx == SelBits'(i)) begin
            grant_last = bus.In_Last[i];
         end
      end
   end

   // Lock is only ever taken or released by round-robin transfers; Mode=0 leaves it alone
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
      end else if (transfer && Mode) begin
         lock_q    <= !grant_last;
         lock_ch_q <= grant_idx;
      end
   end
`endif

   assign bus.Out_Valid   = out_valid_q;
   assign bus.Out_Data    = out_data_q;
   assign bus.Out_Channel = out_channel_q;
endmodule
